// File: rtl/invaders_mem_arb_if.sv
// Bus bundle between the memory arbiter and its requesters and RAM.
// The slave view belongs to the arbiter. The master view is for the
// requesters and the RAM model on the other side.
interface invaders_mem_arb_if #(
  parameter int AW = 16
);
  // Download port
  logic [AW-1:0] dn_addr;
  logic [7:0]    dn_data;
  logic          dn_wr;
  logic          dn_ovf;
  // CPU port
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic          cpu_ack;
  logic [7:0]    cpu_dout;
  // Video port
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [7:0]    vid_dout;
  // RAM port
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic [7:0]    mem_q;
  // Status
  logic          busy;

  modport slave (
    input  dn_addr, dn_data, dn_wr,
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    input  vid_req, vid_addr,
    input  mem_q,
    output dn_ovf, cpu_ack, cpu_dout, vid_ack, vid_dout,
    output mem_addr, mem_din, mem_we, busy
  );

  modport master (
    output dn_addr, dn_data, dn_wr,
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    output vid_req, vid_addr,
    output mem_q,
    input  dn_ovf, cpu_ack, cpu_dout, vid_ack, vid_dout,
    input  mem_addr, mem_din, mem_we, busy
  );
endinterface

// File: rtl/invaders_mem_arb.sv
// Single-port game memory arbiter: download buffer, CPU and video requesters.
// Each access runs IDLE -> ISSUE -> WAIT -> ACK and takes 4 cycles.
// Arbitration happens only in IDLE.
module invaders_mem_arb #(
  parameter int            AW           = 16,
  parameter logic [AW-1:0] ROM_TOP      = AW'(16'h2000),
  parameter int            CPU_MAX_WAIT = 2
) (
  input  logic                 Clk_mem,
  input  logic                 I_RESET,
  invaders_mem_arb_if.slave    bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;
  typedef enum logic [1:0] {W_DN, W_CPU, W_VID} win_t;

  state_t        state_q, state_d;
  win_t          win_q;
  logic          rd_q;
  logic [AW-1:0] mem_addr_q;
  logic [7:0]    mem_din_q;
  logic          mem_we_q;
  logic [7:0]    cpu_dout_q, vid_dout_q;
  logic          pend_q, dn_ovf_q;
  logic [AW-1:0] pend_addr_q;
  logic [7:0]    pend_data_q;
  logic [3:0]    cpu_wait_q;

  logic          gnt_dn, gnt_cpu, gnt_vid;
  logic          cpu_force;
  logic [AW-1:0] dn_sel_addr;
  logic [7:0]    dn_sel_data;
  logic          ack_cpu, ack_vid, busy_s;

  assign cpu_force = (cpu_wait_q >= 4'(CPU_MAX_WAIT));

  // A strobe in IDLE with an empty buffer bypasses the buffer, so it is
  // granted in the same cycle. A full buffer is always served first.
  assign dn_sel_addr = pend_q ? pend_addr_q : bus.dn_addr;
  assign dn_sel_data = pend_q ? pend_data_q : bus.dn_data;

  // Fixed-priority grant, evaluated only while IDLE
  always_comb begin
    gnt_dn  = 1'b0;
    gnt_cpu = 1'b0;
    gnt_vid = 1'b0;
    if (state_q == S_IDLE) begin
      if (pend_q || bus.dn_wr)          gnt_dn  = 1'b1;
      else if (bus.cpu_req && cpu_force) gnt_cpu = 1'b1;
      else if (bus.vid_req)              gnt_vid = 1'b1;
      else if (bus.cpu_req)              gnt_cpu = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge Clk_mem) begin
    if (I_RESET) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_dn || gnt_cpu || gnt_vid) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: ack pulses for the winner and the busy flag
  always_comb begin
    busy_s  = (state_q != S_IDLE);
    ack_cpu = 1'b0;
    ack_vid = 1'b0;
    if (state_q == S_ACK) begin
      ack_cpu = (win_q == W_CPU);
      ack_vid = (win_q == W_VID);
    end
  end

  // Latch the winner's address, data and write enable onto the RAM port.
  // The write enable lasts only for ISSUE.
  always_ff @(posedge Clk_mem) begin
    if (I_RESET) begin
      win_q      <= W_DN;
      rd_q       <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
    end else begin
      if (gnt_dn) begin
        win_q      <= W_DN;
        rd_q       <= 1'b0;
        mem_addr_q <= dn_sel_addr;
        mem_din_q  <= dn_sel_data;
        mem_we_q   <= 1'b1;
      end else if (gnt_cpu) begin
        win_q      <= W_CPU;
        rd_q       <= ~bus.cpu_we;
        mem_addr_q <= bus.cpu_addr;
        mem_din_q  <= bus.cpu_din;
        mem_we_q   <= bus.cpu_we && (bus.cpu_addr >= ROM_TOP);
      end else if (gnt_vid) begin
        win_q      <= W_VID;
        rd_q       <= 1'b1;
        mem_addr_q <= bus.vid_addr;
        mem_we_q   <= 1'b0;
      end
      if (state_q == S_ISSUE) mem_we_q <= 1'b0;
    end
  end

  // Capture read data during WAIT. The data is held until the next read.
  always_ff @(posedge Clk_mem) begin
    if (I_RESET) begin
      cpu_dout_q <= '0;
      vid_dout_q <= '0;
    end else if (state_q == S_WAIT && rd_q) begin
      if (win_q == W_CPU) cpu_dout_q <= bus.mem_q;
      if (win_q == W_VID) vid_dout_q <= bus.mem_q;
    end
  end

  // One-entry download buffer with a sticky overflow flag
  always_ff @(posedge Clk_mem) begin
    if (I_RESET) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      dn_ovf_q    <= 1'b0;
    end else if (bus.dn_wr) begin
      if (pend_q && !gnt_dn) begin
        dn_ovf_q <= 1'b1;
      end else if (pend_q || !gnt_dn) begin
        pend_q      <= 1'b1;
        pend_addr_q <= bus.dn_addr;
        pend_data_q <= bus.dn_data;
      end
    end else if (gnt_dn) begin
      pend_q <= 1'b0;
    end
  end

  // CPU starvation counter: counts video grants taken while the CPU waits
  always_ff @(posedge Clk_mem) begin
    if (I_RESET || !bus.cpu_req || gnt_cpu) cpu_wait_q <= '0;
    else if (gnt_vid && cpu_wait_q != 4'hF) cpu_wait_q <= cpu_wait_q + 4'd1;
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.cpu_ack  = ack_cpu;
  assign bus.vid_ack  = ack_vid;
  assign bus.cpu_dout = cpu_dout_q;
  assign bus.vid_dout = vid_dout_q;
  assign bus.dn_ovf   = dn_ovf_q;
  assign bus.busy     = busy_s;

endmodule

// File: tb/tb_invaders_mem_arb.sv
// Directed bench for invaders_mem_arb with a 1-cycle-latency RAM model.
module tb_invaders_mem_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] ram [0:65535];

  invaders_mem_arb_if #(.AW(16)) bus ();

  invaders_mem_arb #(.AW(16), .ROM_TOP(16'h2000), .CPU_MAX_WAIT(2)) dut (
    .Clk_mem (clk),
    .I_RESET (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM: read data appears one cycle after the address
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    bus.mem_q <= ram[bus.mem_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task check_reset_outputs(input string tag);
    check({tag, " busy"},     16'(bus.busy),     16'h0);
    check({tag, " mem_we"},   16'(bus.mem_we),   16'h0);
    check({tag, " mem_addr"}, bus.mem_addr,      16'h0);
    check({tag, " mem_din"},  16'(bus.mem_din),  16'h0);
    check({tag, " cpu_ack"},  16'(bus.cpu_ack),  16'h0);
    check({tag, " vid_ack"},  16'(bus.vid_ack),  16'h0);
    check({tag, " cpu_dout"}, 16'(bus.cpu_dout), 16'h0);
    check({tag, " vid_dout"}, 16'(bus.vid_dout), 16'h0);
    check({tag, " dn_ovf"},   16'(bus.dn_ovf),   16'h0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h2400] = 8'hA5;
    ram[16'h2401] = 8'h5A;
    ram[16'h1000] = 8'h11;
    bus.dn_addr = '0; bus.dn_data = '0; bus.dn_wr = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.vid_req = 1'b0; bus.vid_addr = '0;
    bus.mem_q = '0;

    // Reset state
    tick; tick;
    check_reset_outputs("rst");
    rst = 1'b0;

    // 1: CPU read of 0x2400
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h2400;
    tick;  // N+1
    check("rd mem_addr N+1", bus.mem_addr, 16'h2400);
    check("rd busy N+1", 16'(bus.busy), 16'h1);
    check("rd ack N+1", 16'(bus.cpu_ack), 16'h0);
    tick;  // N+2
    check("rd busy N+2", 16'(bus.busy), 16'h1);
    check("rd ack N+2", 16'(bus.cpu_ack), 16'h0);
    tick;  // N+3
    check("rd ack N+3", 16'(bus.cpu_ack), 16'h1);
    check("rd dout N+3", 16'(bus.cpu_dout), 16'h00A5);
    check("rd busy N+3", 16'(bus.busy), 16'h1);
    bus.cpu_req = 1'b0;
    tick;  // N+4
    check("rd ack N+4", 16'(bus.cpu_ack), 16'h0);
    check("rd busy N+4", 16'(bus.busy), 16'h0);
    check("rd dout held", 16'(bus.cpu_dout), 16'h00A5);

    // 2a: protected CPU write to 0x1000
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h1000; bus.cpu_din = 8'h3C;
    tick;
    check("wp mem_we N+1", 16'(bus.mem_we), 16'h0);
    check("wp mem_addr N+1", bus.mem_addr, 16'h1000);
    tick;
    check("wp mem_we N+2", 16'(bus.mem_we), 16'h0);
    tick;
    check("wp ack N+3", 16'(bus.cpu_ack), 16'h1);
    check("wp mem_we N+3", 16'(bus.mem_we), 16'h0);
    bus.cpu_req = 1'b0;
    tick;
    check("wp ram 1000", 16'(ram[16'h1000]), 16'h0011);

    // 2b: allowed CPU write to 0x2000
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h2000;
    tick;
    check("wr mem_we N+1", 16'(bus.mem_we), 16'h1);
    check("wr mem_din N+1", 16'(bus.mem_din), 16'h003C);
    tick;
    check("wr mem_we N+2", 16'(bus.mem_we), 16'h0);
    tick;
    check("wr ack N+3", 16'(bus.cpu_ack), 16'h1);
    check("wr dout unchanged", 16'(bus.cpu_dout), 16'h00A5);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    tick;
    check("wr ram 2000", 16'(ram[16'h2000]), 16'h003C);

    // 3: continuous video plus CPU: grant order V, V, C, V
    bus.vid_req = 1'b1; bus.vid_addr = 16'h2401;
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h2400;
    for (int k = 1; k <= 15; k++) begin
      tick;
      check($sformatf("starve vid_ack c%0d", k), 16'(bus.vid_ack),
            16'((k == 3) || (k == 7) || (k == 15)));
      check($sformatf("starve cpu_ack c%0d", k), 16'(bus.cpu_ack), 16'(k == 11));
      if (k == 3)  check("starve vid_dout", 16'(bus.vid_dout), 16'h005A);
      if (k == 11) bus.cpu_req = 1'b0;
      if (k == 15) bus.vid_req = 1'b0;
    end
    tick;
    check("starve idle", 16'(bus.busy), 16'h0);

    // 4: two download strobes during a CPU access, video pending
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h2400;
    tick;  // N+1, ISSUE
    bus.dn_wr = 1'b1; bus.dn_addr = 16'h0010; bus.dn_data = 8'h99;
    tick;  // N+2, WAIT
    check("ovf after 1st", 16'(bus.dn_ovf), 16'h0);
    bus.dn_addr = 16'h0011; bus.dn_data = 8'h88;
    bus.vid_req = 1'b1; bus.vid_addr = 16'h2401;
    tick;  // N+3, ACK
    bus.dn_wr = 1'b0;
    check("ovf after 2nd", 16'(bus.dn_ovf), 16'h1);
    check("buf cpu_ack", 16'(bus.cpu_ack), 16'h1);
    bus.cpu_req = 1'b0;
    tick;  // N+4, IDLE: buffered download granted
    tick;  // N+5
    check("buf mem_addr", bus.mem_addr, 16'h0010);
    check("buf mem_we", 16'(bus.mem_we), 16'h1);
    check("buf mem_din", 16'(bus.mem_din), 16'h0099);
    tick; tick;  // N+7: download ACK slot, no ack
    check("buf no vid_ack", 16'(bus.vid_ack), 16'h0);
    check("buf no cpu_ack", 16'(bus.cpu_ack), 16'h0);
    tick; tick;  // N+9: video issue
    check("buf vid addr", bus.mem_addr, 16'h2401);
    check("buf vid din held", 16'(bus.mem_din), 16'h0099);
    tick; tick;  // N+11
    check("buf vid_ack", 16'(bus.vid_ack), 16'h1);
    check("buf ram 10", 16'(ram[16'h0010]), 16'h0099);
    check("buf ram 11", 16'(ram[16'h0011]), 16'h0000);
    bus.vid_req = 1'b0;
    tick;

    // 5: download, CPU and video all requested in IDLE
    bus.dn_wr = 1'b1; bus.dn_addr = 16'h0005; bus.dn_data = 8'h77;
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h2400;
    bus.vid_req = 1'b1; bus.vid_addr = 16'h2401;
    tick;  // N+1
    bus.dn_wr = 1'b0;
    check("all dn addr", bus.mem_addr, 16'h0005);
    check("all dn we", 16'(bus.mem_we), 16'h1);
    check("all dn din", 16'(bus.mem_din), 16'h0077);
    tick; tick;  // N+3
    check("all dn no cpu_ack", 16'(bus.cpu_ack), 16'h0);
    check("all dn no vid_ack", 16'(bus.vid_ack), 16'h0);
    tick; tick;  // N+5
    check("all vid next", bus.mem_addr, 16'h2401);
    tick; tick;  // N+7
    check("all vid_ack", 16'(bus.vid_ack), 16'h1);
    check("all ram 5", 16'(ram[16'h0005]), 16'h0077);
    bus.vid_req = 1'b0;
    tick; tick; tick; tick;  // N+11
    check("all cpu_ack", 16'(bus.cpu_ack), 16'h1);
    bus.cpu_req = 1'b0;
    tick;
    check("ovf sticky", 16'(bus.dn_ovf), 16'h1);

    // 6: reset during WAIT of a video read, with a download strobe in reset
    bus.vid_req = 1'b1; bus.vid_addr = 16'h2401;
    tick; tick;  // N+2, WAIT
    rst = 1'b1;
    bus.dn_wr = 1'b1; bus.dn_addr = 16'h0020; bus.dn_data = 8'h44;
    tick;
    check_reset_outputs("midrst");
    rst = 1'b0; bus.dn_wr = 1'b0;
    tick;  // M+1
    check("post rst addr", bus.mem_addr, 16'h2401);
    check("post rst we", 16'(bus.mem_we), 16'h0);
    tick; tick;  // M+3
    check("post rst vid_ack", 16'(bus.vid_ack), 16'h1);
    check("post rst vid_dout", 16'(bus.vid_dout), 16'h005A);
    bus.vid_req = 1'b0;
    tick; tick; tick; tick;
    check("post rst busy", 16'(bus.busy), 16'h0);
    check("rst dn ignored", 16'(ram[16'h0020]), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
